// File: rtl/seq_pattern_trigger.sv
// Ordered-pattern trigger: asserts Tj_Trig once DEPTH configured values have
// been seen on the qualified state bus, in order. Supports strict or lenient
// mismatch handling, an inter-advance timeout, sticky or pulse output and a
// saturating count of completed sequences.
module seq_pattern_trigger #(
  parameter int                      WIDTH    = 128,
  parameter int                      DEPTH    = 4,
  parameter logic [DEPTH*WIDTH-1:0]  PATTERNS = {128'h1,
                                                 128'h0,
                                                 128'h00112233_44556677_8899aabb_ccddeeff,
                                                 128'h3243f6a8_885a308d_313198a2_e0370734},
  parameter bit                      STRICT   = 1'b1,
  parameter bit                      STICKY   = 1'b1,
  parameter int                      TIMEOUT  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             state,
  input  logic                         state_vld,
  output logic                         Tj_Trig,
  output logic [$clog2(DEPTH+1)-1:0]   progress,
  output logic [7:0]                   trig_count
);

  localparam int             IW   = $clog2(DEPTH + 1);
  localparam int             NM   = 1 << IW;
  localparam logic [IW-1:0]  LAST = IW'(DEPTH);
  // Timer only ever needs to reach TIMEOUT-1 before it fires.
  localparam int             TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [IW-1:0] idx_reg, idx_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          trig_reg;
  logic [7:0]    count_reg;
  logic          advance;
  logic          enters;

  // Match flags padded to a power of two so idx can index them directly;
  // slots at and beyond DEPTH never match.
  logic [NM-1:0] match;

  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_match
      if (gi < DEPTH) begin : g_cmp
        assign match[gi] = (state == PATTERNS[gi*WIDTH +: WIDTH]);
      end else begin : g_pad
        assign match[gi] = 1'b0;
      end
    end
  endgenerate

  // Next-state selection: advance beats timeout, timeout beats mismatch.
  always_comb begin
    idx_next   = idx_reg;
    timer_next = '0;
    advance    = state_vld && (idx_reg != LAST) && match[idx_reg];
    if (idx_reg == LAST) begin
      // Pulse mode re-evaluates the sample against the first pattern.
      if (!STICKY) begin
        idx_next = (state_vld && match[0]) ? IW'(1) : '0;
      end
    end else if (advance) begin
      idx_next = idx_reg + 1'b1;
    end else if ((TIMEOUT > 0) && (idx_reg != '0) && (timer_reg == TLIM)) begin
      idx_next = '0;
    end else if (STRICT && state_vld) begin
      // A mismatching sample that is itself the first pattern restarts at 1.
      idx_next = match[0] ? IW'(1) : '0;
    end else if ((TIMEOUT > 0) && (idx_reg != '0)) begin
      timer_next = timer_reg + 1'b1;
    end
  end

  // A completion is any entry into the triggered index, including a pulse-mode
  // re-trigger with DEPTH=1; a held sticky trigger is not a new completion.
  assign enters = (idx_next == LAST) && !(STICKY && (idx_reg == LAST));

  // State, timer, registered trigger and saturating completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg   <= '0;
      timer_reg <= '0;
      trig_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      idx_reg   <= idx_next;
      timer_reg <= timer_next;
      trig_reg  <= (idx_next == LAST);
      if (enters && (count_reg != 8'hff)) begin
        count_reg <= count_reg + 8'd1;
      end
    end
  end

  assign Tj_Trig    = trig_reg;
  assign progress   = idx_reg;
  assign trig_count = count_reg;

endmodule
